// File: rtl/fifo_rd_ctrl_pkg.sv
// rtl/fifo_rd_ctrl_pkg.sv - shared types for the FIFO read-side burst sequencer
package fifo_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } rd_ctrl_state_t;

  // Burst framing carried alongside each word through the in-flight pipe and skid buffer.
  typedef struct packed {
    logic sop;
    logic eop;
  } rd_tag_t;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry in-order valid/ready buffer with occupancy count
module stream_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push;
  logic         pop;

  // The producer only pushes with credit in hand, so there is no input-side ready.
  assign push     = s_tvalid;
  assign pop      = m_tvalid & m_tready;
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = mem[rd_ptr];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// rtl/fifo_rd_burst_ctrl.sv - reads the dual-clock FIFO in bursts onto a sop/eop-framed stream
module fifo_rd_burst_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 3,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              rd_clk_i,
  input  logic              aclr_i,
  input  logic              enable_i,
  input  logic              fifo_rd_empty_i,
  input  logic [AWIDTH-1:0] fifo_rd_usedw_i,
  input  logic [DWIDTH-1:0] fifo_rd_data_i,
  output logic              fifo_rd_req_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_sop_o,
  output logic              src_eop_o,
  output logic              busy_o
);

  localparam int LW = AWIDTH + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [LW-1:0] DEPTH_LV = LW'(2 ** AWIDTH);
  localparam logic [LW-1:0] BURST_LV = LW'(BURST_LEN);
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    rd_tag_t           tag;
  } rd_entry_t;

  rd_ctrl_state_t state, state_next;
  logic [LW-1:0]  words_left, words_left_next;
  logic           sop_pending, sop_pending_next;
  logic [CW-1:0]  idle_cnt;
  logic [LW-1:0]  level, prev_level;
  logic           idle_run, flush_go;
  logic           inflight_valid;
  rd_tag_t        inflight_tag, req_tag;
  logic [1:0]     buf_count;
  logic [2:0]     occupancy;
  logic           pop, credit;
  rd_entry_t      in_entry, out_entry;

  always_comb begin
    level = '0;
    if (!fifo_rd_empty_i) begin
      level = (fifo_rd_usedw_i == '0) ? DEPTH_LV : {1'b0, fifo_rd_usedw_i};
    end
  end

  // Counting this cycle's pop lets a req overlap the word leaving, keeping 1 word/cycle.
  assign pop           = src_valid_o & src_ready_i;
  assign occupancy     = 3'(buf_count) - 3'(pop) + 3'(inflight_valid);
  assign credit        = (occupancy < 3'd2);
  assign fifo_rd_req_o = (state != IDLE) & ~fifo_rd_empty_i & credit;
  assign req_tag       = '{sop: sop_pending, eop: (words_left == LW'(1))};

  assign idle_run = enable_i && (level != '0) && (level < BURST_LV);
  assign flush_go = idle_run && (level == prev_level) && (idle_cnt == IDLE_MAX);

  always_comb begin
    state_next       = state;
    words_left_next  = words_left;
    sop_pending_next = sop_pending;
    unique case (state)
      IDLE: begin
        if (enable_i && level >= BURST_LV) begin
          state_next       = BURST;
          words_left_next  = BURST_LV;
          sop_pending_next = 1'b1;
        end else if (flush_go) begin
          state_next       = FLUSH;
          words_left_next  = level;
          sop_pending_next = 1'b1;
        end
      end
      BURST, FLUSH: begin
        if (fifo_rd_req_o) begin
          words_left_next  = words_left - LW'(1);
          sop_pending_next = 1'b0;
          if (words_left == LW'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      state          <= IDLE;
      words_left     <= '0;
      sop_pending    <= 1'b0;
      idle_cnt       <= '0;
      prev_level     <= '0;
      inflight_valid <= 1'b0;
      inflight_tag   <= '0;
    end else begin
      state          <= state_next;
      words_left     <= words_left_next;
      sop_pending    <= sop_pending_next;
      prev_level     <= level;
      inflight_valid <= fifo_rd_req_o;
      inflight_tag   <= req_tag;
      if (state != IDLE || state_next != IDLE || !idle_run) begin
        idle_cnt <= '0;
      end else if (level != prev_level) begin
        idle_cnt <= CW'(1);
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign in_entry = '{data: fifo_rd_data_i, tag: inflight_tag};

  stream_skid_buf #(
    .W($bits(rd_entry_t))
  ) u_skid (
    .clk      (rd_clk_i),
    .aclr     (aclr_i),
    .s_tdata  (in_entry),
    .s_tvalid (inflight_valid),
    .m_tdata  (out_entry),
    .m_tvalid (src_valid_o),
    .m_tready (src_ready_i),
    .count    (buf_count)
  );

  assign src_data_o = out_entry.data;
  assign src_sop_o  = src_valid_o & out_entry.tag.sop;
  assign src_eop_o  = src_valid_o & out_entry.tag.eop;
  assign busy_o     = (state != IDLE) | inflight_valid | (buf_count != 2'd0);

endmodule
